mem_arbiter_ctrl: RTL

Sequencing controller and two-way arbiter in front of the 1024 x 8 byte-wide program/data memory. Shares the single byte port between an instruction-fetch requester (word reads only) and a data requester (byte/word reads and writes). Assembles 32-bit words from four consecutive byte beats, big-endian: the byte at the base address is bits [31:24]. Sits between the core's fetch/load-store units and the memory array.

---
 rtl/mem_arbiter_ctrl_pkg.sv | 24 ++
 rtl/mem_arbiter_ctrl_rr_arbiter2.sv | 34 +++
 rtl/mem_arbiter_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared types and constants for the byte-port memory arbiter/sequencer.
// Contents: FSM state enum, access-size and port-id encodings, word beat count,
//           and a helper that flags word accesses not aligned to 4 bytes.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      LAST   = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic       SIZE_BYTE  = 1'b0;
   localparam logic       SIZE_WORD  = 1'b1;
   localparam logic [2:0] BEATS_WORD = 3'd4;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   function automatic logic is_misaligned(input logic size, input logic [1:0] lsb);
      return (size == SIZE_WORD) && (lsb != 2'b00);
   endfunction

endpackage

// File: rtl/mem_arbiter_ctrl_rr_arbiter2.sv
// Two-requester round-robin arbiter with a last-grant register.
// Ports: i_en gates both grants; i_req_fetch / i_req_data are the requests;
//        o_gnt_fetch / o_gnt_data are one-hot (or zero) combinational grants.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_req_fetch,
   input  logic i_req_data,
   output logic o_gnt_fetch,
   output logic o_gnt_data
);

   logic r_last_grant;
   logic w_pick_fetch;

   // Fetch wins when it is alone, or on a tie when data was granted last.
   assign w_pick_fetch = i_req_fetch && (!i_req_data || (r_last_grant == PORT_D));
   assign o_gnt_fetch  = i_en && w_pick_fetch;
   assign o_gnt_data   = i_en && i_req_data && !w_pick_fetch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= PORT_D;
      end else if (o_gnt_fetch) begin
         r_last_grant <= PORT_I;
      end else if (o_gnt_data) begin
         r_last_grant <= PORT_D;
      end
   end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Arbitrates a fetch port and a data port onto one byte-wide memory port and
// sequences 1- or 4-beat big-endian accesses, one access in flight at a time.
// Ports: i_req_*/i_rsp_* fetch (word reads), d_req_*/d_rsp_* data (byte/word
//        read/write), mem_* byte memory with one-cycle read latency.
module mem_arbiter_ctrl
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req_valid,
   output logic              i_req_ready,
   input  logic [ADDR_W-1:0] i_req_addr,
   output logic              i_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [31:0]       i_rsp_rdata,
   output logic              i_rsp_err,
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic              d_req_we,
   input  logic              d_req_size,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [31:0]       d_req_wdata,
   output logic              d_rsp_valid,
   input  logic              d_rsp_ready,
   output logic [31:0]       d_rsp_rdata,
   output logic              d_rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   state_t            r_state, w_state_nxt;
   logic              r_port;
   logic              r_we;
   logic              r_err;
   logic [ADDR_W-1:0] r_base;
   logic [1:0]        r_idx;
   logic [2:0]        r_cnt;
   logic [31:0]       r_wsh;
   logic [31:0]       r_rdata;

   logic              w_gnt_i, w_gnt_d, w_acc, w_acc_size, w_acc_we, w_mis;
   logic [ADDR_W-1:0] w_acc_addr;
   logic              w_rsp_take;

   rr_arbiter2 u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_en        (r_state == IDLE),
      .i_req_fetch (i_req_valid),
      .i_req_data  (d_req_valid),
      .o_gnt_fetch (w_gnt_i),
      .o_gnt_data  (w_gnt_d)
   );

   // A grant is only issued to a valid requester, so grant == handshake.
   assign i_req_ready = w_gnt_i;
   assign d_req_ready = w_gnt_d;
   assign w_acc       = w_gnt_i || w_gnt_d;
   assign w_acc_size  = w_gnt_d ? d_req_size : SIZE_WORD;
   assign w_acc_we    = w_gnt_d && d_req_we;
   assign w_acc_addr  = w_gnt_d ? d_req_addr : i_req_addr;
   assign w_mis       = is_misaligned(w_acc_size, w_acc_addr[1:0]);
   assign w_rsp_take  = (r_state == RESP) && ((r_port == PORT_D) ? d_rsp_ready : i_rsp_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = 8'h00;
      i_rsp_valid = 1'b0;
      d_rsp_valid = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_acc) w_state_nxt = w_mis ? RESP : ACCESS;
         end
         ACCESS: begin
            mem_addr = r_base + {{(ADDR_W-2){1'b0}}, r_idx};
            mem_we   = r_we;
            if (r_we) mem_wdata = r_wsh[31:24];
            if (r_cnt == 3'd1) w_state_nxt = LAST;
         end
         LAST: begin
            w_state_nxt = RESP;
         end
         RESP: begin
            i_rsp_valid = (r_port == PORT_I);
            d_rsp_valid = (r_port == PORT_D);
            if (w_rsp_take) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_port  <= PORT_I;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_base  <= '0;
         r_idx   <= 2'd0;
         r_cnt   <= 3'd0;
         r_wsh   <= 32'h0;
         r_rdata <= 32'h0;
      end else begin
         if ((r_state == IDLE) && w_acc) begin
            r_port  <= w_gnt_d ? PORT_D : PORT_I;
            r_we    <= w_acc_we && !w_mis;
            r_err   <= w_mis;
            r_base  <= w_acc_addr;
            r_idx   <= 2'd0;
            r_cnt   <= (w_acc_size == SIZE_WORD) ? BEATS_WORD : 3'd1;
            // Byte writes pre-position their data in the top lane so both
            // sizes emit from [31:24].
            r_wsh   <= (w_acc_size == SIZE_WORD) ? d_req_wdata : {d_req_wdata[7:0], 24'h0};
            r_rdata <= 32'h0;
         end else if (r_state == ACCESS) begin
            r_cnt <= r_cnt - 3'd1;
            r_idx <= r_idx + 2'd1;
            r_wsh <= {r_wsh[23:0], 8'h00};
            // Read data trails the address by one cycle; beat 0 data is not
            // back yet on the first ACCESS cycle.
            if (!r_we && (r_idx != 2'd0)) r_rdata <= {r_rdata[23:0], mem_rdata};
         end else if (r_state == LAST) begin
            if (!r_we) r_rdata <= {r_rdata[23:0], mem_rdata};
         end
      end
   end

   assign i_rsp_rdata = i_rsp_valid ? r_rdata : 32'h0;
   assign i_rsp_err   = i_rsp_valid && r_err;
   assign d_rsp_rdata = d_rsp_valid ? r_rdata : 32'h0;
   assign d_rsp_err   = d_rsp_valid && r_err;

endmodule
